// File: rtl/register_load_arbiter_pkg.sv
// +--------------------------------------------------------------------+
// | register_load_arbiter_pkg: state codes and helpers shared by bank   |
// | controllers.                                 Revision: 1.0          |
// +--------------------------------------------------------------------+
`default_nettype none

package register_load_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/register_load_arbiter_rr_priority_pick.sv
// +--------------------------------------------------------------------+
// | rr_priority_pick: first set request at or after ptr, wrapping.      |
// |                                              Revision: 1.0          |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_priority_pick
  import register_load_arbiter_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDW   = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDW-1:0]   i_ptr,
  output logic             o_valid,
  output logic [IDW-1:0]   o_index
);

  logic [IDW-1:0] w_idx;

  // Scan from the far end so the candidate closest to ptr is the last write.
  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    w_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = IDW'((int'(i_ptr) + k) % N_REQ);
      if (i_req[w_idx]) begin
        o_valid = 1'b1;
        o_index = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/register_load_arbiter.sv
// +--------------------------------------------------------------------+
// | register_load_arbiter: round-robin grant and one-cycle load of a    |
// | shared parallel-load register bank.          Revision: 1.0          |
// +--------------------------------------------------------------------+
`default_nettype none

module register_load_arbiter
  import register_load_arbiter_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 8,
  parameter  int CNT_W = 16,
  localparam int IDW   = clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset_async,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data_in,
  output logic [N_REQ-1:0]       ack,
  output logic                   carga,
  output logic [WIDTH-1:0]       In,
  output logic [IDW-1:0]         grant_id,
  output logic                   busy,
  output logic [CNT_W-1:0]       load_cnt
);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [IDW-1:0]   r_ptr;
  logic             w_pick_valid;
  logic [IDW-1:0]   w_pick_idx;
  logic [WIDTH-1:0] w_pick_data;
  logic             w_carga_nxt;
  logic             w_busy_nxt;
  logic [N_REQ-1:0] w_ack_nxt;
  logic [N_REQ-1:0] r_ack;
  logic             r_carga;
  logic [WIDTH-1:0] r_in;
  logic [IDW-1:0]   r_grant_id;
  logic             r_busy;
  logic [CNT_W-1:0] r_load_cnt;

  rr_priority_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_index (w_pick_idx)
  );

  always_comb begin
    w_pick_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick_idx == IDW'(i)) w_pick_data = data_in[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset_async) begin
    if (!reset_async) r_state <= ST_IDLE;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_pick_valid) w_state_nxt = ST_GRANT;
      ST_GRANT: w_state_nxt = ST_ACK;
      ST_ACK:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and then registered.
  always_comb begin
    w_carga_nxt = (w_state_nxt == ST_GRANT);
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
    w_ack_nxt   = '0;
    if (w_state_nxt == ST_ACK) w_ack_nxt[r_grant_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_async) begin
    if (!reset_async) begin
      r_carga    <= 1'b0;
      r_ack      <= '0;
      r_busy     <= 1'b0;
      r_in       <= '0;
      r_grant_id <= '0;
      r_ptr      <= '0;
      r_load_cnt <= '0;
    end else begin
      r_carga <= w_carga_nxt;
      r_ack   <= w_ack_nxt;
      r_busy  <= w_busy_nxt;
      if (r_state == ST_IDLE && w_pick_valid) begin
        r_grant_id <= w_pick_idx;
        r_in       <= w_pick_data;
      end
      if (r_state == ST_GRANT) begin
        r_ptr      <= (r_grant_id == IDW'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;
        r_load_cnt <= r_load_cnt + 1'b1;
      end
    end
  end

  assign ack      = r_ack;
  assign carga    = r_carga;
  assign In       = r_in;
  assign grant_id = r_grant_id;
  assign busy     = r_busy;
  assign load_cnt = r_load_cnt;

endmodule

`default_nettype wire
